uart_echo_responder: RTL
========================

# uart_echo_responder

Far-end UART responder: deserializes bytes arriving on `rx_serial`, buffers them in a small FIFO, and retransmits each byte on `tx_serial`. It is the device-side counterpart to the `UART_TX`/`UART_RX` pair: the host transmits, this block answers. Framing is fixed at 8N1, LSB first, idle-high. Flow control, framing-error and overflow status are exposed for the bench and for the top level.

## Interface
- `CLKS_PER_BIT`, 434, clk cycles per bit (50 MHz / 115200); legal range ≥ 4.
- `FIFO_DEPTH`, 8, echo buffer depth in bytes; power of two, ≥ 2.
- `clk`  in  1  single clock; every flop is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_serial`  in  1  asynchronous serial input, idle high.
- `tx_hold`  in  1  while high, no new TX frame starts; the frame in progress completes.
- `tx_serial`  out  1  serial output, idle high.
- `tx_busy`  out  1  high from the frame-load cycle through the last stop-bit cycle.
- `rx_byte`  out  8  last correctly framed byte received.
- `rx_dv`  out  1  one-cycle pulse when `rx_byte` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overflow`  out  1  sticky; set when a byte is dropped because the FIFO is full. Cleared only by `rst`.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

## Operation
- `rx_serial` passes through a 2-flop synchronizer whose flops reset to 1. All RX logic uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a synchronized low enters START with the bit counter cleared.
  - START: at count CLKS_PER_BIT/2 (integer division), resample. High returns to IDLE as a glitch. Low enters DATA.
  - DATA: sample every CLKS_PER_BIT cycles into bit 0..7, LSB first. After bit 7, enter STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High: update `rx_byte`, pulse `rx_dv`, write to the FIFO, return to IDLE.
    - Low: pulse `frame_err`, discard the byte, enter WAIT_IDLE.
  - WAIT_IDLE: return to IDLE on the first synchronized high.
- FIFO write when full: the byte is dropped and `overflow` is set. Exception: a pop in the same cycle frees a slot, so the write is accepted.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged. Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty and `tx_hold` is low, pop into the shift register and enter START. `tx_busy` rises in this cycle.
  - START: `tx_serial` is 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: `tx_serial` is 1 for CLKS_PER_BIT cycles, then return to IDLE.
- Raising `tx_hold` mid-frame has no effect on the current frame.
- RX and TX run independently, so receiving while transmitting is legal.

## Timing
- Reset values:
  - `tx_serial`=1
  - `tx_busy`=0
  - `rx_byte`=8'h00
  - `rx_dv`=0
  - `frame_err`=0
  - `overflow`=0
  - `fifo_count`=0
- Reset effects: both FSMs go to IDLE and the FIFO empties.
- Reset mid-frame: `tx_serial` is high on the cycle after `rst` is sampled. The truncated frame on the line is accepted behaviour.
- Pin to RX logic: 2 cycles of synchronizer latency.
- `rx_dv` to first TX bit, with TX idle, FIFO empty and `tx_hold` low:
  - `tx_busy` rises 1 cycle after `rx_dv`.
  - `tx_serial` falls 2 cycles after `rx_dv`.
- TX frame length: exactly 10·CLKS_PER_BIT cycles of line time.
- Back-to-back TX frames: consecutive frames are separated by exactly 1 idle-high cycle (the pop cycle).
- All outputs are registered.

## Configuration
- `UART_ECHO_UPCASE_EN` defined: a byte in 8'h61–8'h7A ('a'–'z') is transmitted with bit 5 cleared (uppercase). The conversion is applied at FIFO write. `rx_byte` always carries the unmodified received byte.
- `UART_ECHO_UPCASE_EN` undefined: bytes are echoed unmodified.

## Test plan
- All scenarios use CLKS_PER_BIT=16 and a 20 ns clk.
- Single byte: host sends 8'h4B.
  - `rx_dv` pulses once with `rx_byte`=8'h4B.
  - `tx_serial` falls 2 cycles later and carries a 160-cycle frame decoding to 8'h4B. `tx_busy` spans it.
- Upcase: host sends 8'h6B.
  - With `UART_ECHO_UPCASE_EN`: echo is 8'h4B.
  - Without it: echo is 8'h6B.
  - `rx_byte`=8'h6B in both builds.
- Overflow: FIFO_DEPTH=8, `tx_hold`=1, host sends 8'h00..8'h08.
  - After the 9th byte: `fifo_count`=8 and `overflow`=1.
  - Release `tx_hold`: exactly 8'h00..8'h07 are echoed, with 1-cycle gaps between frames.
- Glitch and framing:
  - `rx_serial` low for 4 cycles: no `rx_dv` and no TX activity.
  - Frame with stop bit 0: `frame_err` pulses once, `fifo_count` stays 0, nothing is echoed.
- Reset mid-echo: assert `rst` during TX data bit 3 with 2 bytes buffered.
  - Next cycle: `tx_serial`=1, `tx_busy`=0, `fifo_count`=0.
  - No further frames are transmitted.
  - A subsequent 8'h4B is echoed normally.

Source files
------------

// File: rtl/uart_echo_responder.sv
// 8N1 UART echo responder: receiver -> byte FIFO -> transmitter, with hold, framing-error and overflow status.
// Optional feature macro: UART_ECHO_UPCASE_EN (lowercase ASCII is upper-cased as it enters the FIFO).
`timescale 1ns/1ps
module uart_echo_responder #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_serial,
   input  logic                          tx_hold,
   output logic                          tx_serial,
   output logic                          tx_busy,
   output logic [7:0]                    rx_byte,
   output logic                          rx_dv,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

   localparam logic [2:0] RX_IDLE      = 3'd0;
   localparam logic [2:0] RX_START     = 3'd1;
   localparam logic [2:0] RX_DATA      = 3'd2;
   localparam logic [2:0] RX_STOP      = 3'd3;
   localparam logic [2:0] RX_WAIT_IDLE = 3'd4;

   localparam logic [1:0] TX_IDLE  = 2'd0;
   localparam logic [1:0] TX_START = 2'd1;
   localparam logic [1:0] TX_DATA  = 2'd2;
   localparam logic [1:0] TX_STOP  = 2'd3;

   logic             rx_meta;
   logic             rx_sync;
   logic [2:0]       rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_shift;
   logic             push_req;
   logic             push_ok;
   logic [7:0]       push_data;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop;

   logic [1:0]       tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_shift;

   // Synchronizer flops reset high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx_serial;
         rx_sync <= rx_meta;
      end
   end

   assign push_req = (rx_state == RX_STOP) && (rx_cnt == CNT_LAST) && rx_sync;

   always_comb begin
      push_data = rx_shift;
`ifdef UART_ECHO_UPCASE_EN
      if ((rx_shift >= 8'h61) && (rx_shift <= 8'h7A)) begin
         push_data = rx_shift & 8'hDF;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state  <= RX_IDLE;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         rx_byte   <= '0;
         rx_dv     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_dv     <= 1'b0;
         frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  rx_state <= RX_START;
                  rx_cnt   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt == CNT_HALF) begin
                  rx_cnt   <= '0;
                  rx_bit   <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            RX_DATA: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) begin
                     rx_state <= RX_STOP;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            RX_STOP: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt <= '0;
                  if (rx_sync) begin
                     rx_byte  <= rx_shift;
                     rx_dv    <= 1'b1;
                     rx_state <= RX_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     rx_state  <= RX_WAIT_IDLE;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            RX_WAIT_IDLE: begin
               if (rx_sync) begin
                  rx_state <= RX_IDLE;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted then.
   assign pop     = (tx_state == TX_IDLE) && (fifo_count != '0) && !tx_hold;
   assign push_ok = push_req && ((fifo_count != FIFO_FULL) || pop);

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (push_req && !push_ok) begin
            overflow <= 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + COUNT_ONE;
            2'b01:   fifo_count <= fifo_count - COUNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // tx_serial follows the state one cycle late; tx_busy stays up through that final stop-bit cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state  <= TX_IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '0;
         tx_serial <= 1'b1;
         tx_busy   <= 1'b0;
      end else begin
         tx_busy <= pop || (tx_state != TX_IDLE);
         case (tx_state)
            TX_IDLE: begin
               tx_serial <= 1'b1;
               if (pop) begin
                  tx_shift <= mem[rd_ptr];
                  tx_cnt   <= '0;
                  tx_bit   <= '0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               tx_serial <= 1'b0;
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            TX_DATA: begin
               tx_serial <= tx_shift[0];
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bit   <= tx_bit + 3'd1;
                  if (tx_bit == 3'd7) begin
                     tx_state <= TX_STOP;
                  end
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            TX_STOP: begin
               tx_serial <= 1'b1;
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_state <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
         endcase
      end
   end

endmodule
